// File: rtl/oc_pkg.sv
// oc_pkg: shared constants and state encoding for the operand-collector array
package oc_pkg;
    localparam int DEF_NUM_OC    = 4;
    localparam int DEF_NUM_SRC   = 2;
    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_DATA_W    = 256;
    localparam int DEF_META_W    = 80;
    localparam int OCW = $clog2(DEF_NUM_OC);
    localparam int SLW = $clog2(DEF_NUM_SRC);
    localparam logic [1:0] OC_IDLE    = 2'd0;
    localparam logic [1:0] OC_COLLECT = 2'd1;
    localparam logic [1:0] OC_READY   = 2'd2;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/oc_collector_entry.sv
// oc_collector_entry: one collector slot group with its FSM, done bits, data and metadata
module oc_collector_entry
    import oc_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int META_W  = DEF_META_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_alloc,
    input  logic [META_W-1:0]         i_meta,
    input  logic [NUM_SRC-1:0]        i_src_need,
    input  logic [NUM_SRC-1:0]        i_spe_vld,
    input  logic [NUM_SRC*DATA_W-1:0] i_spe_data,
    input  logic [NUM_SRC-1:0]        i_wr_en,
    input  logic [NUM_SRC*DATA_W-1:0] i_wr_data,
    input  logic                      i_grant,
    output logic [1:0]                o_state,
    output logic [NUM_SRC-1:0]        o_done,
    output logic [NUM_SRC*DATA_W-1:0] o_data,
    output logic [META_W-1:0]         o_meta
);
    logic [1:0]                r_state;
    logic [NUM_SRC-1:0]        r_done;
    logic [NUM_SRC*DATA_W-1:0] r_data;
    logic [META_W-1:0]         r_meta;
    logic [NUM_SRC-1:0]        w_init_done;
    logic [NUM_SRC*DATA_W-1:0] w_init_data;
    logic [NUM_SRC*DATA_W-1:0] w_col_data;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_slot
        assign w_init_done[s] = ~i_src_need[s] | i_spe_vld[s];
        assign w_init_data[s*DATA_W +: DATA_W] = !i_src_need[s] ? '0 :
            i_spe_vld[s] ? i_spe_data[s*DATA_W +: DATA_W] : r_data[s*DATA_W +: DATA_W];
        assign w_col_data[s*DATA_W +: DATA_W] = i_wr_en[s] ? i_wr_data[s*DATA_W +: DATA_W]
                                                           : r_data[s*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OC_IDLE;
            r_done  <= '0;
            r_data  <= '0;
            r_meta  <= '0;
        end else if (r_state == OC_IDLE && i_alloc) begin
            r_meta  <= i_meta;
            r_done  <= w_init_done;
            r_data  <= w_init_data;
            r_state <= &w_init_done ? OC_READY : OC_COLLECT;
        end else if (r_state == OC_COLLECT) begin
            r_done  <= r_done | i_wr_en;
            r_data  <= w_col_data;
            if (&(r_done | i_wr_en)) r_state <= OC_READY;
        end else if (r_state == OC_READY && i_grant) begin
            r_state <= OC_IDLE;
        end
    end

    assign o_state = r_state;
    assign o_done  = r_done;
    assign o_data  = r_data;
    assign o_meta  = r_meta;
endmodule

// File: rtl/oc_collector_array.sv
// oc_collector_array: allocates collector entries, routes bank returns into slots,
// raises per-entry ready and releases entries on a scheduler grant
module oc_collector_array
    import oc_pkg::*;
#(
    parameter int NUM_OC    = DEF_NUM_OC,
    parameter int NUM_SRC   = DEF_NUM_SRC,
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int META_W    = DEF_META_W
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   i_alloc_valid,
    output logic                                   o_alloc_ready,
    output logic [idx_w(NUM_OC)-1:0]               o_alloc_ocid,
    input  logic [META_W-1:0]                      i_alloc_meta,
    input  logic [NUM_SRC-1:0]                     i_alloc_src_need,
    input  logic [NUM_SRC-1:0]                     i_alloc_spe_vld,
    input  logic [NUM_SRC*DATA_W-1:0]              i_alloc_spe_data,
    input  logic [NUM_BANKS-1:0]                   i_bk_vld,
    input  logic [NUM_BANKS*idx_w(NUM_OC)-1:0]     i_bk_ocid,
    input  logic [NUM_BANKS*idx_w(NUM_SRC)-1:0]    i_bk_slot,
    input  logic [NUM_BANKS*DATA_W-1:0]            i_bk_data,
    input  logic [NUM_OC-1:0]                      i_grant,
    output logic [NUM_OC-1:0]                      o_oc_rdy,
    output logic [NUM_OC-1:0]                      o_oc_busy,
    output logic [NUM_OC*NUM_SRC*DATA_W-1:0]       o_oc_data,
    output logic [NUM_OC*META_W-1:0]               o_oc_meta,
    output logic                                   o_err
);
    localparam int OW  = idx_w(NUM_OC);
    localparam int SW  = idx_w(NUM_SRC);
    localparam int SDW = NUM_SRC * DATA_W;

    logic [1:0]          w_state   [NUM_OC];
    logic [NUM_SRC-1:0]  w_done    [NUM_OC];
    logic [NUM_SRC-1:0]  w_wr_en   [NUM_OC];
    logic [SDW-1:0]      w_wr_data [NUM_OC];
    logic [OW-1:0]       w_bk_ocid [NUM_BANKS];
    logic [SW-1:0]       w_bk_slot [NUM_BANKS];
    logic [DATA_W-1:0]   w_bk_data [NUM_BANKS];
    logic [NUM_OC-1:0]   w_idle, w_alloc, w_grant;
    logic                w_onehot, w_bad, r_err;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign w_bk_ocid[b] = i_bk_ocid[b*OW +: OW];
        assign w_bk_slot[b] = i_bk_slot[b*SW +: SW];
        assign w_bk_data[b] = i_bk_data[b*DATA_W +: DATA_W];
    end

    // Reset holds every entry IDLE, so acceptance is additionally gated by rst_n
    assign o_alloc_ready = rst_n && (|w_idle);
    always_comb begin
        o_alloc_ocid = '0;
        for (int e = NUM_OC - 1; e >= 0; e--)
            if (w_idle[e]) o_alloc_ocid = OW'(e);
    end

    assign w_onehot = (i_grant & (i_grant - NUM_OC'(1))) == '0;
    assign w_grant  = w_onehot ? (i_grant & o_oc_rdy) : '0;

    // Banks are walked high to low so the lowest index overwrites on collision
    always_comb begin
        w_bad = 1'b0;
        for (int e = 0; e < NUM_OC; e++) begin
            w_wr_en[e]   = '0;
            w_wr_data[e] = '0;
        end
        for (int b = NUM_BANKS - 1; b >= 0; b--) begin
            if (i_bk_vld[b]) begin
                if (int'(w_bk_ocid[b]) >= NUM_OC || int'(w_bk_slot[b]) >= NUM_SRC ||
                    w_state[w_bk_ocid[b]] != OC_COLLECT || w_done[w_bk_ocid[b]][w_bk_slot[b]])
                    w_bad = 1'b1;
                else begin
                    w_wr_en[w_bk_ocid[b]][w_bk_slot[b]] = 1'b1;
                    w_wr_data[w_bk_ocid[b]][w_bk_slot[b]*DATA_W +: DATA_W] = w_bk_data[b];
                end
            end
            for (int c = 0; c < b; c++)
                if (i_bk_vld[b] && i_bk_vld[c] && w_bk_ocid[b] == w_bk_ocid[c] &&
                    w_bk_slot[b] == w_bk_slot[c])
                    w_bad = 1'b1;
        end
        if (!w_onehot || (i_grant & ~o_oc_rdy) != '0) w_bad = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else if (w_bad) r_err <= 1'b1;
    end
    assign o_err = r_err;

    for (genvar e = 0; e < NUM_OC; e++) begin : g_oc
        assign w_alloc[e]   = i_alloc_valid && o_alloc_ready && o_alloc_ocid == OW'(e);
        assign w_idle[e]    = w_state[e] == OC_IDLE;
        assign o_oc_rdy[e]  = w_state[e] == OC_READY;
        assign o_oc_busy[e] = !w_idle[e];
        oc_collector_entry #(
            .NUM_SRC (NUM_SRC),
            .DATA_W  (DATA_W),
            .META_W  (META_W)
        ) u_entry (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_alloc    (w_alloc[e]),
            .i_meta     (i_alloc_meta),
            .i_src_need (i_alloc_src_need),
            .i_spe_vld  (i_alloc_spe_vld),
            .i_spe_data (i_alloc_spe_data),
            .i_wr_en    (w_wr_en[e]),
            .i_wr_data  (w_wr_data[e]),
            .i_grant    (w_grant[e]),
            .o_state    (w_state[e]),
            .o_done     (w_done[e]),
            .o_data     (o_oc_data[e*SDW +: SDW]),
            .o_meta     (o_oc_meta[e*META_W +: META_W])
        );
    end
endmodule

// File: doc/oc_collector_array.md
Name: oc_collector_array

Overview:
- Parametrised operand-collector array between the register allocation unit (RAU) and the ALU/MEM dispatch scheduler.
- Allocates a free collector entry per incoming instruction and gathers up to NUM_SRC operands per entry, from register-bank returns or from RAU-supplied special values.
- Raises per-entry ready, and releases the entry on a scheduler grant.
- Generalises the fixed 4-unit/2-source/4-bank collector with a real allocation handshake, per-slot tagging and error detection.

Parameters:
- NUM_OC, 4, number of collector entries
- NUM_SRC, 2, operand slots per entry
- NUM_BANKS, 4, register-bank return ports
- DATA_W, 256, operand width (8 lanes x 32 bits)
- META_W, 80, packed pass-through instruction metadata (warp id, instr, imme, ALUop, mask, dst, flags)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- alloc_valid  in  1  RAU offers an instruction
- alloc_ready  out  1  at least one entry IDLE
- alloc_ocid  out  $clog2(NUM_OC)  entry that takes the offered instruction
- alloc_meta  in  META_W  metadata latched on accept
- alloc_src_need  in  NUM_SRC  slot requires an operand
- alloc_spe_vld  in  NUM_SRC  slot filled directly from alloc_spe_data
- alloc_spe_data  in  NUM_SRC*DATA_W  special/immediate operand values
- bk_vld  in  NUM_BANKS  bank read data valid this cycle
- bk_ocid  in  NUM_BANKS*$clog2(NUM_OC)  destination entry per bank
- bk_slot  in  NUM_BANKS*$clog2(NUM_SRC)  destination slot per bank
- bk_data  in  NUM_BANKS*DATA_W  bank read data
- grant  in  NUM_OC  scheduler grant (ALU|MEM OR'd), one-hot or zero
- oc_rdy  out  NUM_OC  entry READY
- oc_busy  out  NUM_OC  entry not IDLE
- oc_data  out  NUM_OC*NUM_SRC*DATA_W  collected operands
- oc_meta  out  NUM_OC*META_W  latched metadata
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst low, async):
  - all entries IDLE; oc_rdy=0, oc_busy=0, oc_data=0, oc_meta=0, err=0.
  - alloc_ready is forced 0 while rst is low.
  - Reset asserted mid-collection discards every entry.
- Per-entry FSM: IDLE -> COLLECT -> READY -> IDLE.
- alloc_ready = OR of registered IDLE flags. alloc_ocid = lowest-index IDLE entry.
- Accept (alloc_valid & alloc_ready, at edge):
  - target entry latches meta.
  - Per slot: !need -> done, data 0. need&spe_vld -> done, data from spe. Otherwise pending.
  - If all slots are done, entry goes IDLE -> READY directly (1-cycle latency). Otherwise it goes to COLLECT.
- Bank return: each valid bank writes bk_data into slot (bk_ocid, bk_slot) if that entry is COLLECT and the slot is pending; the slot is marked done.
- Several returns in one cycle to different slots are all accepted.
- COLLECT -> READY on the edge where the last pending slot completes. oc_rdy is visible the following cycle.
- Error cases (err set, sticky until reset):
  - Return addressed to an IDLE/READY entry, or to an already-done slot: dropped.
  - Two banks targeting the same (entry, slot) in one cycle: lowest bank index wins.
  - Grant to a non-READY entry: ignored.
  - More than one grant bit set: ignored.
- Grant on a READY entry: entry -> IDLE at the edge. oc_data/oc_meta stay valid during the grant cycle.
- An entry freed by a grant is not visible to alloc_ready until the next cycle, so there is no same-cycle grant/alloc reuse.
- Data and metadata registers hold their value in IDLE; they are cleared only by reset.

Decomposition:
- Shared package oc_pkg: OCW=$clog2(NUM_OC), SLW=$clog2(NUM_SRC), state encoding (OC_IDLE=2'd0, OC_COLLECT=2'd1, OC_READY=2'd2).
- Sub-module oc_collector_entry (one per entry) holds the FSM, slot done bits, data and meta registers.
- Top level owns the priority encoder, bank-return decode and err flag.

Test Plan:
- Reset, then alloc with need=2'b11, spe_vld=2'b01 -> alloc_ocid=0; one cycle after bank1 returns slot1 to entry 0, oc_rdy[0]=1 with correct data.
- Alloc with need=2'b00 -> oc_rdy[0]=1 the next cycle; grant[0] -> oc_busy[0]=0 the cycle after.
- Four back-to-back allocs with NUM_OC=4 -> ocids 0,1,2,3; alloc_ready=0; fifth offer held. grant[2] -> next alloc gets ocid 2.
- bk0 and bk3 both target entry 1 slot 0 in the same cycle -> bk0 data stored, err=1.
- Return to an IDLE entry, or grant to a COLLECT entry -> state unchanged, err=1.
- Drop rst mid-COLLECT -> all outputs 0 immediately; after release alloc_ocid=0.
